alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised execute-stage unit combining the ALUOp/funct decoder with the datapath ALU and an iterative multiply/divide engine. It owns the HI/LO registers. It exposes a valid/ready input handshake so that the pipeline stalls while a multi-cycle operation is in flight. It sits in EX, replacing the separate decoder plus combinational ALU pair.

## Interface
- XLEN, 32: datapath width; must be ≥ 8 and even.
- CNT_W, $clog2(XLEN)+1: iteration counter width.

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept; 1 only in IDLE
- alu_op  in  4  main-control op class: 0000 add, 0001 sub, 0011 and, 0100 or, 0101 xor, 0010 R-type
- funct  in  6  R-type function field, used only when alu_op=0010
- src_a, src_b  in  XLEN  operands (rs, rt/imm)
- flush  in  1  abort in-flight mul/div, drop any offered op
- out_valid  out  1  one-cycle result strobe
- result  out  XLEN  registered result
- zero  out  1  result == 0, registered with result
- illegal  out  1  undecodable alu_op/funct, qualified by out_valid

## Operation
- Accept when in_valid && in_ready && !flush.
- Single-cycle ops:
  - R-type funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed), 101011 sltu, 010000 mfhi, 010010 mflo.
  - Add/sub wrap modulo 2^XLEN; there is no overflow trap.
  - slt/sltu return 1 or 0, zero-extended.
- Multi-cycle ops:
  - funct 011000 mult, 011001 multu, 011010 div, 011011 divu.
  - HI/LO written at completion; result = new LO.
- Illegal encoding: result = 0, illegal = 1, HI/LO unchanged, completes as a single-cycle op.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE→MUL/DIV on an accepted mul/div; operands are latched there.
  - Signed ops convert to magnitudes and latch the result-sign bits.
  - MUL: shift-add, one bit per cycle, XLEN cycles.
  - DIV: restoring, one bit per cycle, XLEN cycles.
  - →FIN when the counter reaches XLEN.
  - FIN: apply sign fix-up, write HI/LO, →IDLE.
- Signed rules:
  - Product sign = a[XLEN-1]^b[XLEN-1].
  - Quotient sign = XOR of operand signs.
  - Remainder sign = dividend sign.
  - MIN/−1 gives LO=MIN, HI=0 with no special case.
- Divide by zero (src_b==0):
  - Detected at accept; does not enter DIV.
  - LO = all ones, HI = src_a.
  - Completes with single-cycle latency.
- flush:
  - In MUL/DIV/FIN → IDLE next edge; no out_valid, HI/LO unchanged.
  - In IDLE → offered op dropped.
  - flush has priority over a same-cycle accept and over FIN.
- Reset: state IDLE, HI=LO=0, counter 0, out_valid=0, result=0, zero=0, illegal=0; in_ready=1 in the first cycle after reset.
- Reset mid-operation: the operation is lost and HI/LO are cleared.

## Timing
- Single-cycle ops: out_valid is high in the cycle after the accept edge (latency 1); back-to-back accepts are allowed every cycle.
- mul/div: in_ready=0 from the cycle after accept through FIN.
- mul/div completion: out_valid pulses XLEN+2 cycles after the accept edge.
  - in_ready returns to 1 in that same cycle.
  - HI/LO hold the new values in that cycle, so an mfhi accepted then reads them.
- mfhi/mflo read HI/LO as of the accept cycle.
- out_valid is a single-cycle pulse with no backpressure; the consumer must capture it.

## Configuration
- MULDIV_EN defined: mult/multu/div/divu/mfhi/mflo are decoded, and HI/LO, the FSM and the counter are present.
- MULDIV_EN undefined:
  - Those six functs decode as illegal.
  - No HI/LO registers exist.
  - in_ready is tied to 1 and the FSM is reduced to IDLE.

## Structure
- Shared package alu_pkg holds:
  - ALUOp class constants.
  - funct code constants.
  - Internal ALU-operation codes (0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1000 xor, plus new nor/sltu/mfhi/mflo codes).
  - FSM state encoding.
- Sub-module muldiv_seq contains the MUL/DIV/FIN datapath, counter and HI/LO.
- The top holds the decode, the single-cycle ALU, the handshake and the output registers.

## Test plan
All scenarios use XLEN=32.
- Reset: hold rst_n=0 for 2 cycles → out_valid=0, result=0, in_ready=1; mfhi then returns 0.
- add 0x7FFFFFFF+1 → result 0x80000000, zero=0 at +1 cycle. sub 5−5 → result 0, zero=1. sltu 1 vs 0xFFFFFFFF → 1. slt same operands → 0.
- mult −3×7 → out_valid at +34 cycles; LO=0xFFFFFFEB, HI=0xFFFFFFFF; in_ready low for cycles +1..+33.
- div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 → at +1 cycle LO=0xFFFFFFFF, HI=7.
- Start divu, assert flush at +10 → no out_valid, in_ready=1 at +11, mflo returns the previous LO.
- alu_op=0010, funct=111111 → illegal=1, result=0; with MULDIV_EN undefined, mult → illegal=1 at +1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: ALUOp classes, R-type funct codes,
// internal ALU control codes and the multiply/divide sequencer states.
package alu_pkg;

  localparam logic [3:0] ALUOP_ADD   = 4'b0000;
  localparam logic [3:0] ALUOP_SUB   = 4'b0001;
  localparam logic [3:0] ALUOP_RTYPE = 4'b0010;
  localparam logic [3:0] ALUOP_AND   = 4'b0011;
  localparam logic [3:0] ALUOP_OR    = 4'b0100;
  localparam logic [3:0] ALUOP_XOR   = 4'b0101;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // ALU_MULDIV marks an op handed to the sequencer; ALU_ILL marks an undecodable one.
  typedef enum logic [3:0] {
    ALU_AND    = 4'b0000,
    ALU_OR     = 4'b0001,
    ALU_ADD    = 4'b0010,
    ALU_SUB    = 4'b0110,
    ALU_SLT    = 4'b0111,
    ALU_XOR    = 4'b1000,
    ALU_NOR    = 4'b1001,
    ALU_SLTU   = 4'b1010,
    ALU_MFHI   = 4'b1011,
    ALU_MFLO   = 4'b1100,
    ALU_MULDIV = 4'b1101,
    ALU_ILL    = 4'b1111
  } alu_ctl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIN  = 2'b11
  } md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider that owns HI and LO.
// Present only when MULDIV_EN is defined.
`ifdef MULDIV_EN
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic            dz_i,
  input  logic            div_i,
  input  logic            sgn_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            idle_o,
  output logic            fin_o,
  output logic [XLEN-1:0] lo_fin_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] p_q, p_d, p_neg_s;
  logic [XLEN-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   hi_fin_s, lo_fin_s, a_mag_s, b_mag_s, q_mag_s, r_mag_s;
  logic [XLEN:0]     mul_sum_s, rem_sh_s, rem_sub_s;
  logic              div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;

  // p holds {HI-side, LO-side}: product for MUL, {remainder, quotient} for DIV.
  assign a_mag_s  = (sgn_i && a_i[XLEN-1]) ? -a_i : a_i;
  assign b_mag_s  = (sgn_i && b_i[XLEN-1]) ? -b_i : b_i;
  assign q_mag_s  = p_q[XLEN-1:0];
  assign r_mag_s  = p_q[2*XLEN-1:XLEN];
  assign p_neg_s  = -p_q;
  assign lo_fin_o = lo_fin_s;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

  // Sign fix-up applied in FIN.
  always_comb begin
    if (div_q) begin
      lo_fin_s = neg_lo_q ? -q_mag_s : q_mag_s;
      hi_fin_s = neg_hi_q ? -r_mag_s : r_mag_s;
    end else if (neg_lo_q) begin
      {hi_fin_s, lo_fin_s} = p_neg_s;
    end else begin
      {hi_fin_s, lo_fin_s} = p_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush returns to IDLE from any busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (start_i) begin
          state_d = div_i ? ST_DIV : ST_MUL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = ST_FIN;
        end else begin
          state_d = state_q;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    idle_o = (state_q == ST_IDLE);
    fin_o  = (state_q == ST_FIN) && !flush_i;
  end

  // Datapath next state: operand latch, one iteration per cycle, HI/LO writes.
  always_comb begin
    cnt_d     = cnt_q;
    p_d       = p_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_d     = div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    mul_sum_s = {1'b0, r_mag_s} + (p_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
    rem_sh_s  = {r_mag_s, q_mag_s[XLEN-1]};
    rem_sub_s = rem_sh_s - {1'b0, m_q};
    case (state_q)
      ST_IDLE: begin
        if (dz_i) begin
          hi_d = a_i;
          lo_d = {XLEN{1'b1}};
        end else if (start_i) begin
          cnt_d    = {CNT_W{1'b0}};
          p_d      = {{XLEN{1'b0}}, a_mag_s};
          m_d      = b_mag_s;
          div_d    = div_i;
          neg_lo_d = sgn_i && (a_i[XLEN-1] ^ b_i[XLEN-1]);
          neg_hi_d = sgn_i && a_i[XLEN-1];
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_MUL: begin
        p_d   = {mul_sum_s, q_mag_s[XLEN-1:1]};
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      ST_DIV: begin
        // A clear borrow bit means the shifted remainder covers the divisor.
        if (!rem_sub_s[XLEN]) begin
          p_d = {rem_sub_s[XLEN-1:0], q_mag_s[XLEN-2:0], 1'b1};
        end else begin
          p_d = {rem_sh_s[XLEN-1:0], q_mag_s[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      ST_FIN: begin
        if (!flush_i) begin
          hi_d = hi_fin_s;
          lo_d = lo_fin_s;
        end else begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= {CNT_W{1'b0}};
      p_q      <= {(2*XLEN){1'b0}};
      m_q      <= {XLEN{1'b0}};
      hi_q     <= {XLEN{1'b0}};
      lo_q     <= {XLEN{1'b0}};
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// EX-stage unit: ALUOp/funct decode, single-cycle ALU, handshake and output registers.
// Define MULDIV_EN to add mult/multu/div/divu/mfhi/mflo via muldiv_seq.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  alu_ctl_e        ctl_s;
  logic            illegal_s, accept_s, in_ready_s, md_start_s, md_fin_s;
  logic [XLEN-1:0] alu_res_s, md_lo_fin_s;
  logic            out_valid_q, out_valid_d, zero_q, zero_d, illegal_q, illegal_d;
  logic [XLEN-1:0] result_q, result_d;
`ifdef MULDIV_EN
  logic            is_md_s, md_div_s, md_sgn_s, dz_s;
  logic [XLEN-1:0] md_hi_s, md_lo_s;
`endif

  // Decode ALUOp class and R-type funct into an internal control code.
  always_comb begin
    ctl_s = ALU_ILL;
`ifdef MULDIV_EN
    md_div_s = 1'b0;
    md_sgn_s = 1'b0;
`endif
    case (alu_op)
      ALUOP_ADD: ctl_s = ALU_ADD;
      ALUOP_SUB: ctl_s = ALU_SUB;
      ALUOP_AND: ctl_s = ALU_AND;
      ALUOP_OR:  ctl_s = ALU_OR;
      ALUOP_XOR: ctl_s = ALU_XOR;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:  ctl_s = ALU_ADD;
          FN_SUB:  ctl_s = ALU_SUB;
          FN_AND:  ctl_s = ALU_AND;
          FN_OR:   ctl_s = ALU_OR;
          FN_XOR:  ctl_s = ALU_XOR;
          FN_NOR:  ctl_s = ALU_NOR;
          FN_SLT:  ctl_s = ALU_SLT;
          FN_SLTU: ctl_s = ALU_SLTU;
`ifdef MULDIV_EN
          FN_MFHI:  ctl_s = ALU_MFHI;
          FN_MFLO:  ctl_s = ALU_MFLO;
          FN_MULT: begin
            ctl_s    = ALU_MULDIV;
            md_sgn_s = 1'b1;
          end
          FN_MULTU: ctl_s = ALU_MULDIV;
          FN_DIV: begin
            ctl_s    = ALU_MULDIV;
            md_div_s = 1'b1;
            md_sgn_s = 1'b1;
          end
          FN_DIVU: begin
            ctl_s    = ALU_MULDIV;
            md_div_s = 1'b1;
          end
`else
          FN_MFHI, FN_MFLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: ctl_s = ALU_ILL;
`endif
          default: ctl_s = ALU_ILL;
        endcase
      end
      default: ctl_s = ALU_ILL;
    endcase
  end

  assign illegal_s = (ctl_s == ALU_ILL);
  assign accept_s  = in_valid && in_ready_s && !flush;

  // Single-cycle datapath; ALU_MULDIV only completes here as a divide by zero.
  always_comb begin
    case (ctl_s)
      ALU_ADD:    alu_res_s = src_a + src_b;
      ALU_SUB:    alu_res_s = src_a - src_b;
      ALU_AND:    alu_res_s = src_a & src_b;
      ALU_OR:     alu_res_s = src_a | src_b;
      ALU_XOR:    alu_res_s = src_a ^ src_b;
      ALU_NOR:    alu_res_s = ~(src_a | src_b);
      ALU_SLT:    alu_res_s = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU:   alu_res_s = {{(XLEN-1){1'b0}}, (src_a < src_b)};
`ifdef MULDIV_EN
      ALU_MFHI:   alu_res_s = md_hi_s;
      ALU_MFLO:   alu_res_s = md_lo_s;
`endif
      ALU_MULDIV: alu_res_s = {XLEN{1'b1}};
      default:    alu_res_s = {XLEN{1'b0}};
    endcase
  end

`ifdef MULDIV_EN
  assign is_md_s    = (ctl_s == ALU_MULDIV);
  assign dz_s       = accept_s && is_md_s && md_div_s && (src_b == {XLEN{1'b0}});
  assign md_start_s = accept_s && is_md_s && !dz_s;

  muldiv_seq #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush),
    .start_i  (md_start_s),
    .dz_i     (dz_s),
    .div_i    (md_div_s),
    .sgn_i    (md_sgn_s),
    .a_i      (src_a),
    .b_i      (src_b),
    .idle_o   (in_ready_s),
    .fin_o    (md_fin_s),
    .lo_fin_o (md_lo_fin_s),
    .hi_o     (md_hi_s),
    .lo_o     (md_lo_s)
  );
`else
  assign in_ready_s  = 1'b1;
  assign md_start_s  = 1'b0;
  assign md_fin_s    = 1'b0;
  assign md_lo_fin_s = {XLEN{1'b0}};
`endif

  // Output next state: sequencer completion or a single-cycle accept.
  always_comb begin
    out_valid_d = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    if (md_fin_s) begin
      out_valid_d = 1'b1;
      result_d    = md_lo_fin_s;
      zero_d      = (md_lo_fin_s == {XLEN{1'b0}});
      illegal_d   = 1'b0;
    end else if (accept_s && !md_start_s) begin
      out_valid_d = 1'b1;
      result_d    = alu_res_s;
      zero_d      = (alu_res_s == {XLEN{1'b0}});
      illegal_d   = illegal_s;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= {XLEN{1'b0}};
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed scoreboard bench for alu_exec_unit (XLEN=32); mul/div checks need MULDIV_EN.
module tb_alu_exec_unit;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, zero, illegal;
  logic [3:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b, result;
  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .src_a(src_a), .src_b(src_b), .flush(flush),
    .out_valid(out_valid), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b101010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'b101011: return (a < b) ? 32'd1 : 32'd0;
      default:   return 32'd0;
    endcase
  endfunction

  // Drives one op for one clock edge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ei, input logic push);
    exp_t e;
    alu_op = op; funct = fn; src_a = a; src_b = b; in_valid = 1'b1;
    if (push) begin
      e.res = er; e.z = (er == 32'd0); e.ill = ei;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int lat, input logic chk_busy);
    int n;
    exp_t e;
    n = 0;
    while (out_valid !== 1'b1 && n < 64) begin
      if (chk_busy) begin
        total++;
        assert (in_ready === 1'b0) else begin bad++; $error("FAIL %s_busy: in_ready=%b want 0 at +%0d", tag, in_ready, n + 1); end
      end
      @(negedge clk);
      n++;
    end
    total++;
    assert (out_valid === 1'b1) else begin bad++; $error("FAIL %s_timeout: out_valid=%b want 1", tag, out_valid); end
    if (out_valid === 1'b1) begin
      total++;
      assert (sb.size() > 0) else begin bad++; $error("FAIL %s_sb: unexpected out_valid, queue empty", tag); end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        assert (n == lat) else begin bad++; $error("FAIL %s_lat: got +%0d want +%0d", tag, n + 1, lat + 1); end
        total++;
        assert (result === e.res) else begin bad++; $error("FAIL %s_res: got %h want %h", tag, result, e.res); end
        total++;
        assert (zero === e.z) else begin bad++; $error("FAIL %s_zero: got %b want %b", tag, zero, e.z); end
        total++;
        assert (illegal === e.ill) else begin bad++; $error("FAIL %s_ill: got %b want %b", tag, illegal, e.ill); end
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic want);
    total++;
    assert (got === want) else begin bad++; $error("FAIL %s: got %b want %b", tag, got, want); end
  endtask

  initial begin
    logic [5:0]  fns [8];
    logic [31:0] ra, rb;
    logic [5:0]  rf;
    int          seen;
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011};
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    alu_op = 4'b0000; funct = 6'b000000; src_a = 32'd0; src_b = 32'd0;

    // Reset held for two cycles.
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_zero", zero, 1'b0);
    check_bit("rst_illegal", illegal, 1'b0);
    total++;
    assert (result === 32'd0) else begin bad++; $error("FAIL rst_result: got %h want 0", result); end
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("post_rst_ready", in_ready, 1'b1);

`ifdef MULDIV_EN
    issue(4'b0010, 6'b010000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);         expect_out("mfhi_rst", 0, 1'b0);
`else
    issue(4'b0010, 6'b010000, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);         expect_out("mfhi_ill", 0, 1'b0);
`endif

    // Single-cycle directed ops.
    issue(4'b0010, 6'b100000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1); expect_out("add_wrap", 0, 1'b0);
    issue(4'b0000, 6'b000000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1);        expect_out("aluop_add", 0, 1'b0);
    issue(4'b0010, 6'b100010, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1);               expect_out("sub_zero", 0, 1'b0);
    issue(4'b0001, 6'b000000, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b1);        expect_out("aluop_sub", 0, 1'b0);
    issue(4'b0010, 6'b101011, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);        expect_out("sltu", 0, 1'b0);
    issue(4'b0010, 6'b101010, 32'h1234, 32'h1234, 32'd0, 1'b0, 1'b1);         expect_out("slt_eq", 0, 1'b0);
    issue(4'b0010, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b1);        expect_out("slt_neg", 0, 1'b0);
    issue(4'b0011, 6'b000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1); expect_out("aluop_and", 0, 1'b0);
    issue(4'b0100, 6'b000000, 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0, 1'b0, 1'b1); expect_out("aluop_or", 0, 1'b0);
    issue(4'b0101, 6'b000000, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b1); expect_out("aluop_xor", 0, 1'b0);
    issue(4'b0010, 6'b100111, 32'h0000FFFF, 32'h00FF0000, 32'hFF000000, 1'b0, 1'b1); expect_out("nor", 0, 1'b0);
    issue(4'b0010, 6'b111111, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1);                expect_out("ill_funct", 0, 1'b0);
    issue(4'b1111, 6'b100000, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1);                expect_out("ill_aluop", 0, 1'b0);

    // Back-to-back random R-type ops against the reference model.
    for (int i = 0; i < 12; i++) begin
      rf = fns[i % 8];
      ra = $urandom;
      rb = (i % 3 == 0) ? ra : $urandom;
      issue(4'b0010, rf, ra, rb, model(rf, ra, rb), 1'b0, 1'b1);
      expect_out("rand", 0, 1'b0);
    end

    // Flush in IDLE drops the offered op.
    alu_op = 4'b0000; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check_bit("flush_idle_drop", out_valid, 1'b0);

`ifdef MULDIV_EN
    issue(4'b0010, 6'b011000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 1'b0, 1'b1); expect_out("mult", 33, 1'b1);
    check_bit("mult_ready_back", in_ready, 1'b1);
    issue(4'b0010, 6'b010000, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1);        expect_out("mult_hi", 0, 1'b0);
    issue(4'b0010, 6'b011001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0, 1'b1); expect_out("multu", 33, 1'b1);
    issue(4'b0010, 6'b010000, 32'd0, 32'd0, 32'd1, 1'b0, 1'b1);               expect_out("multu_hi", 0, 1'b0);
    issue(4'b0010, 6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b1); expect_out("div", 33, 1'b1);
    issue(4'b0010, 6'b010000, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1);        expect_out("div_hi", 0, 1'b0);
    issue(4'b0010, 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1); expect_out("div_min", 33, 1'b1);
    issue(4'b0010, 6'b010000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);               expect_out("div_min_hi", 0, 1'b0);
    issue(4'b0010, 6'b011011, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);            expect_out("divu", 33, 1'b1);
    issue(4'b0010, 6'b010000, 32'd0, 32'd0, 32'd2, 1'b0, 1'b1);               expect_out("divu_hi", 0, 1'b0);
    issue(4'b0010, 6'b011011, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1);        expect_out("divu_dz", 0, 1'b0);
    issue(4'b0010, 6'b010000, 32'd0, 32'd0, 32'd7, 1'b0, 1'b1);               expect_out("dz_hi", 0, 1'b0);

    // divu flushed at +10: no result, HI/LO unchanged.
    issue(4'b0010, 6'b011011, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0);
    seen = 0;
    for (int c = 1; c < 10; c++) begin
      if (out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_bit("flush_ready", in_ready, 1'b1);
    for (int c = 0; c < 30; c++) begin
      if (out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    total++;
    assert (seen == 0) else begin bad++; $error("FAIL flush_no_valid: got %0d strobes want 0", seen); end
    issue(4'b0010, 6'b010010, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1);        expect_out("flush_lo", 0, 1'b0);
    issue(4'b0010, 6'b010000, 32'd0, 32'd0, 32'd7, 1'b0, 1'b1);               expect_out("flush_hi", 0, 1'b0);
`else
    issue(4'b0010, 6'b011000, 32'hFFFFFFFD, 32'd7, 32'd0, 1'b1, 1'b1);        expect_out("mult_ill", 0, 1'b0);
    check_bit("mult_ill_ready", in_ready, 1'b1);
    issue(4'b0010, 6'b011011, 32'd7, 32'd0, 32'd0, 1'b1, 1'b1);               expect_out("divu_ill", 0, 1'b0);
    issue(4'b0010, 6'b011010, 32'd7, 32'd2, 32'd0, 1'b1, 1'b1);               expect_out("div_ill", 0, 1'b0);
    issue(4'b0010, 6'b010010, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);               expect_out("mflo_ill", 0, 1'b0);
`endif

    @(negedge clk);
    check_bit("final_idle_valid", out_valid, 1'b0);
    total++;
    assert (sb.size() == 0) else begin bad++; $error("FAIL sb_drain: %0d entries left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
